// File: rtl/pim_tile_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pim_tile_engine_pkg
// Brief    : Shared sizes, state encoding and helpers for the PIM tile engine.
// Revision : 1.0
// ============================================================================
package pim_tile_engine_pkg;

    localparam int WIDTH             = 32;
    localparam int CHUNK_SIZE        = 2;
    localparam int PIM_UNIT_CAPACITY = 2;

    // Accept edge to result_valid, in clock cycles.
    localparam int PIM_TILE_LATENCY  = CHUNK_SIZE * PIM_UNIT_CAPACITY + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } pim_tile_state_t;

    function automatic int cnt_width(input int bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pim_mac_lane.sv
`default_nettype none
// ============================================================================
// Module   : pim_mac_lane
// Brief    : One result-column multiply-accumulate lane (modulo 2^WIDTH).
// Revision : 1.0
// ============================================================================
module pim_mac_lane #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_out
);

    logic [WIDTH-1:0] w_prod;

    assign w_prod = a * b;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_out <= '0;
        end else if (en) begin
            acc_out <= clr ? '0 : acc_out + w_prod;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pim_tile_engine.sv
`default_nettype none
// ============================================================================
// Module   : pim_tile_engine
// Brief    : Row-serial MAC engine returning the CHUNK_SIZE^2 partial product.
// Revision : 1.0
// ============================================================================
module pim_tile_engine #(
    parameter int ID                = 0,
    parameter int WIDTH             = pim_tile_engine_pkg::WIDTH,
    parameter int CHUNK_SIZE        = pim_tile_engine_pkg::CHUNK_SIZE,
    parameter int PIM_UNIT_CAPACITY = pim_tile_engine_pkg::PIM_UNIT_CAPACITY
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 valid,
    input  logic [CHUNK_SIZE-1:0][PIM_UNIT_CAPACITY-1:0][WIDTH-1:0] matrixA,
    input  logic [PIM_UNIT_CAPACITY-1:0][CHUNK_SIZE-1:0][WIDTH-1:0] matrixB,
    output logic [CHUNK_SIZE*CHUNK_SIZE-1:0][WIDTH-1:0]           result,
    output logic                                                 result_valid,
    output logic                                                 ready,
    output logic                                                 busy
);
    import pim_tile_engine_pkg::*;

    localparam int RW = cnt_width(CHUNK_SIZE);
    localparam int KW = cnt_width(PIM_UNIT_CAPACITY);
    localparam logic [RW-1:0] R_LAST = RW'(CHUNK_SIZE - 1);
    localparam logic [KW-1:0] K_LAST = KW'(PIM_UNIT_CAPACITY - 1);

    if (CHUNK_SIZE < 1 || PIM_UNIT_CAPACITY < 1 || WIDTH < 1 || ID < 0) begin : g_param_check
        $error("pim_tile_engine: illegal parameterisation");
    end

    pim_tile_state_t r_state;
    logic [RW-1:0]   r_row;
    logic [KW-1:0]   r_k;
    logic [CHUNK_SIZE-1:0][PIM_UNIT_CAPACITY-1:0][WIDTH-1:0] r_a;
    logic [PIM_UNIT_CAPACITY-1:0][CHUNK_SIZE-1:0][WIDTH-1:0] r_b;

    logic                                w_start;
    logic                                w_lane_en;
    logic                                w_lane_clr;
    logic [WIDTH-1:0]                    w_a;
    logic [CHUNK_SIZE-1:0][WIDTH-1:0]    w_acc;
    logic [CHUNK_SIZE-1:0][WIDTH-1:0]    w_sum;

    assign w_start    = (r_state == IDLE) && valid;
    assign w_lane_en  = w_start || (r_state == COMPUTE);
    // Lanes restart on a new request and again after each row's last K term.
    assign w_lane_clr = w_start || (r_k == K_LAST);
    assign w_a        = r_a[r_row][r_k];

    for (genvar c = 0; c < CHUNK_SIZE; c++) begin : g_lane
        logic [WIDTH-1:0] w_b;
        assign w_b      = r_b[r_k][c];
        assign w_sum[c] = w_acc[c] + w_a * w_b;

        pim_mac_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .clr     (w_lane_clr),
            .en      (w_lane_en),
            .a       (w_a),
            .b       (w_b),
            .acc_out (w_acc[c])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_row        <= '0;
            r_k          <= '0;
            r_a          <= '0;
            r_b          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            ready        <= 1'b1;
            busy         <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid) begin
                        r_a     <= matrixA;
                        r_b     <= matrixB;
                        r_row   <= '0;
                        r_k     <= '0;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (r_k == K_LAST) begin
                        for (int rr = 0; rr < CHUNK_SIZE; rr++) begin
                            if (r_row == RW'(rr)) begin
                                for (int c = 0; c < CHUNK_SIZE; c++) begin
                                    result[rr*CHUNK_SIZE + c] <= w_sum[c];
                                end
                            end
                        end
                        r_k <= '0;
                        if (r_row == R_LAST) begin
                            result_valid <= 1'b1;
                            r_state      <= DONE;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                DONE: begin
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    ready        <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pim_tile_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_pim_tile_engine
// Brief    : Directed and randomized self-checking bench for pim_tile_engine.
// Revision : 1.0
// ============================================================================
module tb_pim_tile_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, valid, valid8, valid1;

    logic [1:0][1:0][31:0] mA, mB;
    logic [3:0][31:0]      res;
    logic                  rv, rdy, bsy;

    logic [1:0][1:0][7:0]  a8, b8;
    logic [3:0][7:0]       res8;
    logic                  rv8, rdy8, bsy8;

    logic [0:0][0:0][31:0] a1, b1;
    logic [0:0][31:0]      res1;
    logic                  rv1, rdy1, bsy1;

    int compared   = 0;
    int mismatched = 0;

    pim_tile_engine #(.ID(0), .WIDTH(32), .CHUNK_SIZE(2), .PIM_UNIT_CAPACITY(2)) dut (
        .clk(clk), .rst(rst), .valid(valid), .matrixA(mA), .matrixB(mB),
        .result(res), .result_valid(rv), .ready(rdy), .busy(bsy)
    );

    pim_tile_engine #(.ID(1), .WIDTH(8), .CHUNK_SIZE(2), .PIM_UNIT_CAPACITY(2)) dut8 (
        .clk(clk), .rst(rst), .valid(valid8), .matrixA(a8), .matrixB(b8),
        .result(res8), .result_valid(rv8), .ready(rdy8), .busy(bsy8)
    );

    pim_tile_engine #(.ID(2), .WIDTH(32), .CHUNK_SIZE(1), .PIM_UNIT_CAPACITY(1)) dut1 (
        .clk(clk), .rst(rst), .valid(valid1), .matrixA(a1), .matrixB(b1),
        .result(res1), .result_valid(rv1), .ready(rdy1), .busy(bsy1)
    );

    localparam logic [127:0] BASIC_RES = {32'd50, 32'd43, 32'd22, 32'd19};
    localparam logic [127:0] SECOND_RES = {32'd6, 32'd7, 32'd8, 32'd9};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain matrix product, each term and the running sum wrapped to 32 bits.
    function automatic logic [127:0] ref_product(input logic [1:0][1:0][31:0] a,
                                                 input logic [1:0][1:0][31:0] b);
        logic [3:0][31:0] o;
        logic [31:0]      s;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                s = 32'd0;
                for (int k = 0; k < 2; k++) s = s + a[r][k] * b[k][c];
                o[r*2 + c] = s;
            end
        end
        return o;
    endfunction

    task automatic run_op(input logic [1:0][1:0][31:0] a, input logic [1:0][1:0][31:0] b,
                          output logic [127:0] got, output int lat);
        mA = a; mB = b; valid = 1'b1;
        tick();
        valid = 1'b0;
        mA = {$urandom(), $urandom(), $urandom(), $urandom()};
        mB = {$urandom(), $urandom(), $urandom(), $urandom()};
        lat = -1;
        got = '0;
        for (int i = 1; i <= 20; i++) begin
            if (rv) begin
                lat = i;
                got = res;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic load_basic();
        mA[0][0] = 32'd1; mA[0][1] = 32'd2; mA[1][0] = 32'd3; mA[1][1] = 32'd4;
        mB[0][0] = 32'd5; mB[0][1] = 32'd6; mB[1][0] = 32'd7; mB[1][1] = 32'd8;
    endtask

    initial begin
        logic [1:0][1:0][31:0] ra, rb;
        logic [127:0] got;
        int lat;
        int pulses;

        rst = 1'b1; valid = 1'b0; valid8 = 1'b0; valid1 = 1'b0;
        mA = '0; mB = '0; a8 = '0; b8 = '0; a1 = '0; b1 = '0;
        tick(); tick(); tick();

        chk("reset_ready", rdy, 1'b1);
        chk("reset_busy", bsy, 1'b0);
        chk("reset_rv", rv, 1'b0);
        chk("reset_result", res, '0);
        chk("reset_result8", res8, '0);
        chk("reset_result1", res1, '0);
        rst = 1'b0;
        tick();

        // Basic product with valid held high; operands change during COMPUTE.
        load_basic();
        valid = 1'b1;
        tick();
        mA[0][0] = 32'd1; mA[0][1] = 32'd0; mA[1][0] = 32'd0; mA[1][1] = 32'd1;
        mB[0][0] = 32'd9; mB[0][1] = 32'd8; mB[1][0] = 32'd7; mB[1][1] = 32'd6;
        pulses = 0;
        for (int j = 1; j <= 12; j++) begin
            if (rv) pulses++;
            chk($sformatf("b2b_rv_cycle%0d", j), rv, (j == 5 || j == 11));
            if (j <= 5) chk($sformatf("b2b_ready_low_cycle%0d", j), rdy, 1'b0);
            if (j == 5) chk("basic_result", res, BASIC_RES);
            if (j == 6) chk("ready_back_cycle6", rdy, 1'b1);
            if (j == 11) begin
                chk("second_result", res, SECOND_RES);
                valid = 1'b0;
            end
            tick();
        end
        chk("b2b_pulse_count", pulses, 2);
        chk("b2b_idle_after", bsy, 1'b0);

        // A request during COMPUTE must be ignored.
        load_basic();
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        mA = {4{32'd99}};
        valid = 1'b1;
        tick();
        valid = 1'b0;
        pulses = 0;
        for (int j = 3; j <= 12; j++) begin
            if (rv) begin
                pulses++;
                chk("ignored_rv_cycle", j, 5);
                chk("ignored_result", res, BASIC_RES);
            end
            tick();
        end
        chk("ignored_pulse_count", pulses, 1);

        // Reset in the middle of an operation.
        load_basic();
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_result", res, '0);
        chk("midrst_ready", rdy, 1'b1);
        chk("midrst_busy", bsy, 1'b0);
        pulses = 0;
        for (int j = 0; j < 8; j++) begin
            if (rv) pulses++;
            tick();
        end
        chk("midrst_no_pulse", pulses, 0);

        // Reset and valid together: no capture.
        rst = 1'b1; valid = 1'b1;
        tick();
        rst = 1'b0; valid = 1'b0;
        chk("rst_wins_busy", bsy, 1'b0);
        chk("rst_wins_ready", rdy, 1'b1);

        load_basic();
        run_op(mA, mB, got, lat);
        chk("after_rst_latency", lat, 5);
        chk("after_rst_result", got, BASIC_RES);

        // Wrap-around on the 8-bit engine: 2 * 225 = 450 -> 194.
        a8 = {4{8'd15}}; b8 = {4{8'd15}}; valid8 = 1'b1;
        tick();
        valid8 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            if (rv8) begin
                lat = i;
                break;
            end
            tick();
        end
        chk("wrap_latency", lat, 5);
        chk("wrap_result", res8, {4{8'd194}});
        tick();

        // Single-element engine.
        a1[0][0] = 32'd7; b1[0][0] = 32'd6; valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        chk("degen_rv_cycle1", rv1, 1'b0);
        tick();
        chk("degen_rv_cycle2", rv1, 1'b1);
        chk("degen_result", res1, 32'd42);
        tick();
        chk("degen_rv_cycle3", rv1, 1'b0);

        // Randomized operands against the reference product.
        for (int n = 0; n < 10; n++) begin
            for (int r = 0; r < 2; r++) begin
                for (int k = 0; k < 2; k++) begin
                    ra[r][k] = (n < 4) ? 32'($urandom_range(0, 255)) : $urandom();
                    rb[r][k] = (n < 4) ? 32'($urandom_range(0, 255)) : $urandom();
                end
            end
            run_op(ra, rb, got, lat);
            chk($sformatf("rand%0d_latency", n), lat, 5);
            chk($sformatf("rand%0d_result", n), got, ref_product(ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
